// File: rtl/types_pkg.sv
// Shared datapath types for the store path: word/byte types, store size
// encoding and the size-to-byte-count helper.
package types;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } store_size_e;

  // SIZE_X maps to zero bytes; callers reject it before using the count.
  function automatic logic [2:0] size_nbytes(input store_size_e size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_store_req_check.sv
// Combinational store request validator: byte count plus legality.
// Alignment trap is enabled by defining STORE_MISALIGN_TRAP_EN.
module store_req_check
  import types::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  word_t       addr,
  input  store_size_e size,
  output logic [2:0]  nbytes,
  output logic        illegal
);

  logic [32:0] end_addr;

  always_comb begin
    nbytes   = size_nbytes(size);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    end_addr = {1'b0, addr} + {30'b0, nbytes};
    illegal  = (size == SIZE_X) || (end_addr > 33'(MEM_SIZE));
`ifdef STORE_MISALIGN_TRAP_EN
    if ((size == SIZE_H) && addr[0])
      illegal = 1'b1;
    if ((size == SIZE_W) && (addr[1:0] != 2'b00))
      illegal = 1'b1;
`endif
  end

endmodule

// File: rtl/store_unit.sv
// Byte-serial store engine: accepts one request, writes its bytes
// little-endian one per cycle. Optional macro: STORE_MISALIGN_TRAP_EN.
module store_unit
  import types::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  word_t       req_addr_i,
  input  word_t       req_data_i,
  input  store_size_e req_size_i,
  output logic        mem_we_o,
  output word_t       mem_addr_o,
  output byte_t       mem_wdata_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e     state_reg, state_next;
  word_t      data_reg, data_next;
  logic [2:0] nbytes_reg, nbytes_next;
  logic [2:0] count_reg, count_next;
  logic       mem_we_reg, mem_we_next;
  word_t      mem_addr_reg, mem_addr_next;
  byte_t      mem_wdata_reg, mem_wdata_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic [2:0] chk_nbytes;
  logic       chk_illegal;

  store_req_check #(
    .MEM_SIZE (MEM_SIZE)
  ) u_check (
    .addr    (req_addr_i),
    .size    (req_size_i),
    .nbytes  (chk_nbytes),
    .illegal (chk_illegal)
  );

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    nbytes_next    = nbytes_reg;
    count_next     = count_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          count_next  = 3'd0;
          nbytes_next = chk_nbytes;
          if (chk_illegal) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            // Byte 0 is launched at accept so it appears the next cycle
            state_next     = ST_WRITE;
            mem_we_next    = 1'b1;
            mem_addr_next  = req_addr_i;
            mem_wdata_next = req_data_i[7:0];
            data_next      = req_data_i >> 8;
          end
        end
      end
      ST_WRITE: begin
        if (count_reg == nbytes_reg - 3'd1) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          // data_reg holds the not-yet-written bytes, lowest first
          count_next     = count_reg + 3'd1;
          mem_we_next    = 1'b1;
          mem_addr_next  = mem_addr_reg + 32'd1;
          mem_wdata_next = data_reg[7:0];
          data_next      = data_reg >> 8;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      data_reg      <= '0;
      nbytes_reg    <= '0;
      count_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      nbytes_reg    <= nbytes_next;
      count_reg     <= count_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed testbench for store_unit; per-cycle output logs after each
// accept are compared against hand-computed byte writes and pulses.
module tb_store_unit;
  import types::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  word_t       req_addr_i;
  word_t       req_data_i;
  store_size_e req_size_i;
  logic        mem_we_o;
  word_t       mem_addr_o;
  byte_t       mem_wdata_o;
  logic        done_o;
  logic        err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic  we_log    [1:15];
  word_t addr_log  [1:15];
  byte_t wdata_log [1:15];
  logic  done_log  [1:15];
  logic  err_log   [1:15];
  logic  ready_log [1:15];

  store_unit #(.MEM_SIZE(1024)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_size_i  (req_size_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one request, accepts it on the next edge,
  // then logs n cycles of outputs (cycle 1 = cycle after accept).
  task automatic run_store(input word_t a, input word_t d, input store_size_e s, input int n);
    check_eq("ready_before_accept", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_size_i  = s;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_data_i  = 32'hA5A5_A5A5;
    req_addr_i  = 32'h0000_0155;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_i);
      we_log[c]    = mem_we_o;
      addr_log[c]  = mem_addr_o;
      wdata_log[c] = mem_wdata_o;
      done_log[c]  = done_o;
      err_log[c]   = err_o;
      ready_log[c] = req_ready_o;
    end
    $display("[TB] store addr=0x%08h data=0x%08h size=%0d logged %0d cycles", a, d, s, n);
  endtask

  task automatic expect_wr(input int c, input word_t a, input byte_t d);
    check_eq($sformatf("we_c%0d", c), {31'b0, we_log[c]}, 32'd1);
    check_eq($sformatf("addr_c%0d", c), addr_log[c], a);
    check_eq($sformatf("wdata_c%0d", c), {24'b0, wdata_log[c]}, {24'b0, d});
  endtask

  // Window summary: write count, ready-low count, single done at done_c.
  task automatic expect_end(input int n, input int nwr, input int done_c, input logic err_exp);
    int wr_cnt = 0, busy_cnt = 0, done_cnt = 0;
    for (int c = 1; c <= n; c++) begin
      wr_cnt   += int'(we_log[c]);
      busy_cnt += int'(!ready_log[c]);
      done_cnt += int'(done_log[c]);
    end
    check_eq("write_count", wr_cnt, nwr);
    check_eq("ready_low_cycles", busy_cnt, nwr);
    check_eq("done_count", done_cnt, 1);
    check_eq("done_cycle", {31'b0, done_log[done_c]}, 32'd1);
    check_eq("err_at_done", {31'b0, err_log[done_c]}, {31'b0, err_exp});
    check_eq("ready_at_done", {31'b0, ready_log[done_c]}, 32'd1);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_size_i  = SIZE_B;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check_eq("rst_we", {31'b0, mem_we_o}, 32'd0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_wdata", {24'b0, mem_wdata_o}, 32'd0);
    check_eq("rst_done", {31'b0, done_o}, 32'd0);
    check_eq("rst_err", {31'b0, err_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: word store
    run_store(32'h10, 32'hDEAD_BEEF, SIZE_W, 5);
    expect_wr(1, 32'h10, 8'hEF);
    expect_wr(2, 32'h11, 8'hBE);
    expect_wr(3, 32'h12, 8'hAD);
    expect_wr(4, 32'h13, 8'hDE);
    expect_end(5, 4, 5, 1'b0);

    // 2: byte store, then back-to-back half store in the done cycle
    run_store(32'h3, 32'h1234_5678, SIZE_B, 2);
    expect_wr(1, 32'h3, 8'h78);
    expect_end(2, 1, 2, 1'b0);
    run_store(32'h8, 32'h0000_ABCD, SIZE_H, 3);
    expect_wr(1, 32'h8, 8'hCD);
    expect_wr(2, 32'h9, 8'hAB);
    expect_end(3, 2, 3, 1'b0);

    // 3: misaligned half store
`ifdef STORE_MISALIGN_TRAP_EN
    run_store(32'h5, 32'h0000_ABCD, SIZE_H, 2);
    expect_end(2, 0, 1, 1'b1);
`else
    run_store(32'h5, 32'h0000_ABCD, SIZE_H, 3);
    expect_wr(1, 32'h5, 8'hCD);
    expect_wr(2, 32'h6, 8'hAB);
    expect_end(3, 2, 3, 1'b0);
`endif

    // 4: upper memory bound and 32-bit wrap
    run_store(32'h3FE, 32'h1122_3344, SIZE_W, 2);
    expect_end(2, 0, 1, 1'b1);
    run_store(32'h3FC, 32'h1122_3344, SIZE_W, 5);
    expect_wr(1, 32'h3FC, 8'h44);
    expect_wr(2, 32'h3FD, 8'h33);
    expect_wr(3, 32'h3FE, 8'h22);
    expect_wr(4, 32'h3FF, 8'h11);
    expect_end(5, 4, 5, 1'b0);
    run_store(32'hFFFF_FFFE, 32'h1122_3344, SIZE_W, 2);
    expect_end(2, 0, 1, 1'b1);
    run_store(32'h3FF, 32'h0000_0077, SIZE_B, 2);
    expect_wr(1, 32'h3FF, 8'h77);
    expect_end(2, 1, 2, 1'b0);

    // 5: illegal size code
    run_store(32'h0, 32'hCAFE_F00D, SIZE_X, 2);
    expect_end(2, 0, 1, 1'b1);

    // 6: reset after the second byte of a word store
    run_store(32'h20, 32'h4433_2211, SIZE_W, 2);
    expect_wr(1, 32'h20, 8'h11);
    expect_wr(2, 32'h21, 8'h22);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("post_rst_we", {31'b0, mem_we_o}, 32'd0);
    check_eq("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
    check_eq("post_rst_done", {31'b0, done_o}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check_eq($sformatf("post_rst_idle_we_%0d", c), {31'b0, mem_we_o}, 32'd0);
      check_eq($sformatf("post_rst_idle_done_%0d", c), {31'b0, done_o}, 32'd0);
    end
    $display("[TB] reset during word store at addr=0x20 checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Byte-serial store engine between the execute stage and the byte-addressable data memory; the write-side counterpart of the instruction fetch byte-array read path.
- Accepts one store request (address, data, size) over a valid/ready handshake.
- Writes the stored bytes little-endian, one byte per cycle, through a single-byte memory write port.
- Reports completion with a `done_o` pulse, or rejects illegal requests with `err_o`.

Parameters:
- `MEM_SIZE`, 1024: size of the target memory in bytes. Legal byte addresses are 0 .. `MEM_SIZE-1`.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: store request valid.
- `req_ready_o` out 1: unit can accept a request this cycle.
- `req_addr_i` in `types::word_t`: byte address of the lowest byte.
- `req_data_i` in `types::word_t`: store data; the low bytes are used per size.
- `req_size_i` in `types::store_size_e`: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `mem_we_o` out 1: byte write enable.
- `mem_addr_o` out `types::word_t`: byte write address.
- `mem_wdata_o` out `types::byte_t`: byte write data.
- `done_o` out 1: one-cycle pulse when a request finishes (success or error).
- `err_o` out 1: one-cycle pulse coincident with `done_o` for a rejected request.

Behaviour:
- Single clock. Synchronous active-high reset on `rst_i`.
- Reset values: state IDLE, byte count 0, `req_ready_o`=1 on the first cycle after reset, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `done_o`=0, `err_o`=0.
- States: IDLE, WRITE.
- `req_ready_o` = (state == IDLE). It depends only on the state register, with no combinational path from the request inputs.
- Accept occurs when `req_valid_i` && `req_ready_o` at a rising edge. On accept, `addr`, `data` and `nbytes` (1/2/4) are registered and count is cleared.
- Validation at accept. The request is rejected if either of these holds:
  - size == 3;
  - `addr + nbytes > MEM_SIZE`, evaluated in 33-bit arithmetic so that addresses near 2^32 do not wrap into range.
- Rejected request: no memory write occurs and state stays IDLE. `done_o` and `err_o` are both 1 in the cycle after accept. A new request may be accepted in that same cycle.
- Legal request: state goes to WRITE.
- In WRITE, for each cycle k = 0 .. `nbytes-1`:
  - `mem_we_o`=1;
  - `mem_addr_o` = `addr + k`;
  - `mem_wdata_o` = `data[8k+7:8k]`.
- After the cycle with k = `nbytes-1`, state returns to IDLE and `done_o` pulses for one cycle, coincident with `req_ready_o` returning to 1.
- Write latency: the first byte is written the cycle after accept. A word therefore occupies 4 write cycles, and `req_ready_o` is low for exactly `nbytes` cycles.
- `mem_*` outputs are registered. `mem_addr_o` and `mem_wdata_o` hold their last values while `mem_we_o`=0; they have no meaning in that state.
- Inputs are ignored while in WRITE. Request data may change after accept.
- Reset during WRITE: remaining bytes are not written. Bytes already written are left as they are. Reset values apply on the next cycle.
- `rst_i` takes priority over a coincident accept.

Optional Feature:
- Macro: `STORE_MISALIGN_TRAP_EN`.
- Defined: a half store with `addr[0]`!=0, or a word store with `addr[1:0]`!=0, is rejected with the error behaviour above.
- Undefined: any alignment is legal and is written byte-serially across the natural boundary.

Decomposition:
- Package `types` gains:
  - `byte_t` (logic [7:0]);
  - `store_size_e` (2-bit enum: `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_X`);
  - a function returning `nbytes` from a size.
- `word_t` is reused from the package.
- One natural sub-module: `store_req_check`, the combinational validator. Inputs: addr and size. Outputs: `nbytes` and `illegal`. Parameterised by `MEM_SIZE`. It holds the misalign check under the macro.

Test Plan:
1. Reset; SW addr 0x10, data 0xDEADBEEF → writes 0x10:EF, 0x11:BE, 0x12:AD, 0x13:DE on 4 consecutive cycles starting 1 after accept; `req_ready_o` low 4 cycles; `done_o` one pulse; `err_o`=0.
2. SB addr 0x3, data 0x12345678 → single write 0x03:78; `done_o` 2 cycles after accept; then an immediate back-to-back SH addr 0x8, data 0xABCD → 0x08:CD, 0x09:AB.
3. SH addr 0x5, data 0xABCD → macro undefined: 0x05:CD, 0x06:AB. Macro defined: no `mem_we_o`; `done_o` and `err_o` pulse.
4. SW addr 0x3FE (`MEM_SIZE`=1024) → no writes, `err_o` pulse. SW addr 0x3FC → 4 writes ending at 0x3FF. SW addr 0xFFFFFFFE → `err_o`.
5. `req_size_i`=3, addr 0x0 → `err_o` and `done_o` pulse 1 cycle after accept, no writes, `req_ready_o` stays 1.
6. SW addr 0x20, assert `rst_i` for 1 cycle after the second byte → only 0x20 and 0x21 written; `mem_we_o`=0 and `req_ready_o`=1 the cycle after reset; no `done_o`.
